control_unit: RTL and testbench

Main instruction-decode control unit for the modified 32-bit MIPS datapath. Decodes the 6-bit opcode into datapath control strobes and a 2-bit ALU-operation class for the ALU-control block. Outputs are registered (one-cycle latency) so they align with the decode/execute pipeline boundary. Unsupported opcodes decode to a safe all-zero bubble and raise an illegal flag.

---
 rtl/control_unit_if.sv | 58 +++++
 rtl/control_unit.sv | 147 ++++++++++++++
 tb/tb_control_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Decode request and registered control-strobe bundle between fetch/decode
// and the control unit.
interface control_unit_if;
  logic       op_valid;
  logic [5:0] op;
  logic       regDst;
  logic       aluSrc;
  logic       memToReg;
  logic       regWrite;
  logic       regWrite2;
  logic       memRead;
  logic       memWrite;
  logic       branch;
  logic       branchN;
  logic       lui;
  logic       jump;
  logic       jal;
  logic [1:0] aluop;
  logic       illegal;

  modport master (
    output op_valid,
    output op,
    input  regDst,
    input  aluSrc,
    input  memToReg,
    input  regWrite,
    input  regWrite2,
    input  memRead,
    input  memWrite,
    input  branch,
    input  branchN,
    input  lui,
    input  jump,
    input  jal,
    input  aluop,
    input  illegal
  );

  modport slave (
    input  op_valid,
    input  op,
    output regDst,
    output aluSrc,
    output memToReg,
    output regWrite,
    output regWrite2,
    output memRead,
    output memWrite,
    output branch,
    output branchN,
    output lui,
    output jump,
    output jal,
    output aluop,
    output illegal
  );
endinterface

// File: rtl/control_unit.sv
// Main opcode decoder for the modified MIPS datapath; registered outputs
// line up with the decode/execute boundary.
module control_unit #(
  parameter int OP_W = 6
) (
  input logic         clk,
  input logic         rst_n,
  control_unit_if.slave cu
);

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       regwrite2;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       branchn;
    logic       lui;
    logic       jump;
    logic       jal;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  logic  is_r;
  logic  is_lw;
  logic  is_sw;
  logic  is_beq;
  logic  is_bne;
  logic  is_ori;
  logic  is_j;
  logic  is_jal;
  logic  is_lui;
  ctrl_t dec;
  ctrl_t q;

  assign is_r   = (cu.op == OP_RTYPE);
  assign is_lw  = (cu.op == OP_LW);
  assign is_sw  = (cu.op == OP_SW);
  assign is_beq = (cu.op == OP_BEQ);
  assign is_bne = (cu.op == OP_BNE);
  assign is_ori = (cu.op == OP_ORI);
  assign is_j   = (cu.op == OP_J);
  assign is_jal = (cu.op == OP_JAL);
  assign is_lui = (cu.op == OP_LUI);

  // Unsupported opcodes fall through to a bubble with only illegal set.
  always_comb begin
    dec = '0;
    unique case (1'b1)
      is_r: begin
        dec.regdst    = 1'b1;
        dec.regwrite  = 1'b1;
        dec.regwrite2 = 1'b1;
        dec.aluop     = ALU_FN;
      end
      is_lw: begin
        dec.alusrc   = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        dec.aluop    = ALU_ADD;
      end
      is_sw: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        dec.aluop    = ALU_ADD;
      end
      is_beq: begin
        dec.branch = 1'b1;
        dec.aluop  = ALU_SUB;
      end
      is_bne: begin
        dec.branchn = 1'b1;
        dec.aluop   = ALU_SUB;
      end
      is_ori: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = ALU_OR;
      end
      is_j: begin
        dec.jump  = 1'b1;
        dec.aluop = ALU_ADD;
      end
      is_jal: begin
        dec.jump     = 1'b1;
        dec.jal      = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = ALU_ADD;
      end
      is_lui: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.lui      = 1'b1;
        dec.aluop    = ALU_ADD;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (!cu.op_valid) begin
      q <= '0;
    end else begin
      q <= dec;
    end
  end

  assign cu.regDst    = q.regdst;
  assign cu.aluSrc    = q.alusrc;
  assign cu.memToReg  = q.memtoreg;
  assign cu.regWrite  = q.regwrite;
  assign cu.regWrite2 = q.regwrite2;
  assign cu.memRead   = q.memread;
  assign cu.memWrite  = q.memwrite;
  assign cu.branch    = q.branch;
  assign cu.branchN   = q.branchn;
  assign cu.lui       = q.lui;
  assign cu.jump      = q.jump;
  assign cu.jal       = q.jal;
  assign cu.aluop     = q.aluop;
  assign cu.illegal   = q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed and random-invariant bench for the opcode control unit.
module tb_control_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  control_unit_if bus ();

  control_unit #(.OP_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cu    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rd as mr rw rw2 mrd mw br bn lui j jal aluop[1:0] ill
  logic [14:0] obs;
  assign obs = {bus.regDst, bus.aluSrc, bus.memToReg, bus.regWrite,
                bus.regWrite2, bus.memRead, bus.memWrite, bus.branch,
                bus.branchN, bus.lui, bus.jump, bus.jal, bus.aluop,
                bus.illegal};

  localparam logic [14:0] V_ZERO = 15'b000000000000000;
  localparam logic [14:0] V_R    = 15'b100110000000100;
  localparam logic [14:0] V_LW   = 15'b011101000000000;
  localparam logic [14:0] V_SW   = 15'b010000100000000;
  localparam logic [14:0] V_BEQ  = 15'b000000010000010;
  localparam logic [14:0] V_BNE  = 15'b000000001000010;
  localparam logic [14:0] V_ORI  = 15'b010100000000110;
  localparam logic [14:0] V_J    = 15'b000000000010000;
  localparam logic [14:0] V_JAL  = 15'b000100000011000;
  localparam logic [14:0] V_LUI  = 15'b010100000100000;
  localparam logic [14:0] V_ILL  = 15'b000000000000001;

  task automatic step(input logic rst, input logic v, input logic [5:0] o);
    rst_n        = rst;
    bus.op_valid = v;
    bus.op       = o;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [14:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic o, input logic exp);
    total++;
    assert (o === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  logic [5:0] rop;
  logic       rv;
  int         k;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.op_valid = 1'b1;
    bus.op = 6'b000000;

    step(1'b0, 1'b1, 6'b000000);
    chk("reset_edge1", V_ZERO);
    step(1'b0, 1'b1, 6'b000000);
    chk("reset_edge2", V_ZERO);
    step(1'b1, 1'b1, 6'b000000);
    chk("release_rtype", V_R);

    step(1'b1, 1'b1, 6'b100011); chk("sweep_lw", V_LW);
    step(1'b1, 1'b1, 6'b101011); chk("sweep_sw", V_SW);
    step(1'b1, 1'b1, 6'b000100); chk("sweep_beq", V_BEQ);
    step(1'b1, 1'b1, 6'b000101); chk("sweep_bne", V_BNE);
    step(1'b1, 1'b1, 6'b001101); chk("sweep_ori", V_ORI);
    step(1'b1, 1'b1, 6'b000010); chk("sweep_j", V_J);
    step(1'b1, 1'b1, 6'b000011); chk("sweep_jal", V_JAL);
    step(1'b1, 1'b1, 6'b001111); chk("sweep_lui", V_LUI);
    step(1'b1, 1'b1, 6'b000000); chk("sweep_r", V_R);

    step(1'b1, 1'b1, 6'b111111); chk("illegal_ff", V_ILL);
    step(1'b1, 1'b1, 6'b100011); chk("after_illegal_lw", V_LW);
    step(1'b1, 1'b1, 6'b000001); chk("illegal_01", V_ILL);
    step(1'b1, 1'b1, 6'b001100); chk("illegal_andi", V_ILL);
    step(1'b1, 1'b0, 6'b111111); chk("bubble_clears_illegal", V_ZERO);

    step(1'b1, 1'b1, 6'b100011); chk("bubble_pre_lw", V_LW);
    step(1'b1, 1'b0, 6'b101011); chk("bubble_sw", V_ZERO);

    step(1'b1, 1'b1, 6'b101011); chk("mid_sw", V_SW);
    step(1'b0, 1'b1, 6'b100011); chk("mid_reset", V_ZERO);
    step(1'b1, 1'b1, 6'b000100); chk("post_reset_beq", V_BEQ);
    step(1'b1, 1'b1, 6'b000011); chk("post_reset_jal", V_JAL);

    for (int i = 0; i < 1000; i++) begin
      k  = $urandom_range(0, 11);
      rv = ($urandom_range(0, 3) != 0);
      case (k)
        0: rop = 6'b000000;
        1: rop = 6'b100011;
        2: rop = 6'b101011;
        3: rop = 6'b000100;
        4: rop = 6'b000101;
        5: rop = 6'b001101;
        6: rop = 6'b000010;
        7: rop = 6'b000011;
        8: rop = 6'b001111;
        default: rop = 6'($urandom_range(0, 63));
      endcase
      step(1'b1, rv, rop);
      chk1("inv_mem", bus.memRead & bus.memWrite, 1'b0);
      chk1("inv_br", bus.branch & bus.branchN, 1'b0);
      chk1("inv_jal", bus.jal & ~bus.jump, 1'b0);
      chk1("inv_rw2", bus.regWrite2 & ~bus.regWrite, 1'b0);
      chk1("inv_bubble", ~rv & (|obs), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
